// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-frame instruction cache with register storage.
// A miss stalls in FILL until the memory controller drops iwait, then refills the frame.
module icache_dm #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int unsigned IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fill_addr_q, fill_addr_d;

    logic               valid_q [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS];
    logic [31:0]        data_q  [SETS];

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               lookup_hit;
    logic               fill_we;
    logic               unused_offset;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign fill_idx      = fill_addr_q[IDX_W+1:2];
    assign fill_tag      = fill_addr_q[31:IDX_W+2];
    assign unused_offset = ^{imemaddr[1:0], fill_addr_q[1:0]};

    // Lookup uses only the request and stored frames, never the memory-side inputs.
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        ihit        = 1'b0;
        imemload    = '0;
        iREN        = 1'b0;
        iaddr       = '0;
        fill_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        ihit     = 1'b1;
                        imemload = data_q[req_idx];
                    end else begin
                        fill_addr_d = {imemaddr[31:2], 2'b00};
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = fill_addr_q;
                if (!iwait) begin
                    // Reset on the same edge abandons the fill, so the write is masked too.
                    fill_we = !RST;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (fill_we) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

endmodule
